// File: rtl/sqd_word_sequencer.sv
// Sequencer for a shared serial bit-sequence detector: shifts one parallel word per job into the
// detector, records the detector's Mealy output per bit, and reports a match map and count.
module sqd_word_sequencer #(
  parameter int WIDTH     = 8,
  parameter int CNT_W     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START,
  input  logic [WIDTH-1:0] WORD_IN,
  input  logic             ABORT,
  output logic             READY,
  output logic             DONE,
  output logic [WIDTH-1:0] MATCH_MAP,
  output logic [CNT_W-1:0] MATCH_CNT,
  output logic             DET_X,
  output logic             DET_RESET,
  input  logic             DET_Z
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;
  localparam logic [CNT_W-1:0] K_LAST = CNT_W'(WIDTH - 1);

  logic [0:0]       state_q, state_d;
  logic             ready_q, ready_d;
  logic             done_q, done_d;
  logic             det_reset_q, det_reset_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CNT_W-1:0] k_q, k_d;
  logic [WIDTH-1:0] map_q, map_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] pos_s;
  logic [WIDTH-1:0] pos_mask_s;

  // The shift register empties itself as it shifts, so it reads zero whenever idle.
  assign DET_X      = MSB_FIRST ? shift_q[WIDTH-1] : shift_q[0];
  assign pos_s      = MSB_FIRST ? (K_LAST - k_q) : k_q;
  assign pos_mask_s = {{(WIDTH-1){1'b0}}, 1'b1} << pos_s;

  assign READY     = ready_q;
  assign DONE      = done_q;
  assign MATCH_MAP = map_q;
  assign MATCH_CNT = cnt_q;
  assign DET_RESET = det_reset_q;

  // Next-state and datapath update for the idle/shift job sequence.
  always_comb begin
    state_d     = state_q;
    ready_d     = ready_q;
    done_d      = 1'b0;
    det_reset_d = det_reset_q;
    shift_d     = shift_q;
    k_d         = k_q;
    map_d       = map_q;
    cnt_d       = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (START) begin
          state_d     = ST_SHIFT;
          ready_d     = 1'b0;
          det_reset_d = 1'b0;
          shift_d     = WORD_IN;
          k_d         = {CNT_W{1'b0}};
          map_d       = {WIDTH{1'b0}};
          cnt_d       = {CNT_W{1'b0}};
        end else begin
          ready_d     = 1'b1;
          det_reset_d = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (ABORT) begin
          // Current bit is dropped; partial results stay visible.
          state_d     = ST_IDLE;
          ready_d     = 1'b1;
          det_reset_d = 1'b1;
          shift_d     = {WIDTH{1'b0}};
          k_d         = {CNT_W{1'b0}};
        end else begin
          map_d   = DET_Z ? (map_q | pos_mask_s) : (map_q & ~pos_mask_s);
          cnt_d   = cnt_q + {{(CNT_W-1){1'b0}}, DET_Z};
          shift_d = MSB_FIRST ? {shift_q[WIDTH-2:0], 1'b0} : {1'b0, shift_q[WIDTH-1:1]};
          if (k_q == K_LAST) begin
            state_d     = ST_IDLE;
            ready_d     = 1'b1;
            done_d      = 1'b1;
            det_reset_d = 1'b1;
            k_d         = {CNT_W{1'b0}};
          end else begin
            k_d = k_q + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
      end
      default: begin
        state_d     = ST_IDLE;
        ready_d     = 1'b1;
        det_reset_d = 1'b1;
        shift_d     = {WIDTH{1'b0}};
        k_d         = {CNT_W{1'b0}};
      end
    endcase
  end

  // State and output registers; reset puts the detector in reset immediately.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= ST_IDLE;
      ready_q     <= 1'b1;
      done_q      <= 1'b0;
      det_reset_q <= 1'b1;
      shift_q     <= {WIDTH{1'b0}};
      k_q         <= {CNT_W{1'b0}};
      map_q       <= {WIDTH{1'b0}};
      cnt_q       <= {CNT_W{1'b0}};
    end else begin
      state_q     <= state_d;
      ready_q     <= ready_d;
      done_q      <= done_d;
      det_reset_q <= det_reset_d;
      shift_q     <= shift_d;
      k_q         <= k_d;
      map_q       <= map_d;
      cnt_q       <= cnt_d;
    end
  end

endmodule
